// File: rtl/cic_decimator.sv
// Complex I/Q CIC decimator: N registered integrators at the input rate, a shared
// decimation counter, and N combs evaluated on the registered decimation strobe.
module cic_decimator #(
    parameter int num_of_bits_io  = 16,
    parameter int num_of_stages   = 3,
    parameter int log2_decimation = 6
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             valid_i,
    input  logic signed [num_of_bits_io-1:0] signalr_i,
    input  logic signed [num_of_bits_io-1:0] signali_i,
    output logic signed [num_of_bits_io-1:0] signalr_o,
    output logic signed [num_of_bits_io-1:0] signali_o,
    output logic                             valid_o
);

    localparam int B = num_of_bits_io;
    localparam int N = num_of_stages;
    localparam int L = log2_decimation;
    localparam int W = B + N * L;

    // Strobe semantics: valid_i qualifies signalr_i/signali_i in the same cycle and there is
    // no backpressure; valid_o is a one-cycle pulse and the outputs hold until the next pulse.

    logic signed [W-1:0] intr [N];
    logic signed [W-1:0] inti [N];
    logic signed [W-1:0] zr   [N];
    logic signed [W-1:0] zi   [N];
    logic signed [W-1:0] cr   [N+1];
    logic signed [W-1:0] ci   [N+1];
    logic        [L-1:0] count;
    logic                dec_q;

    logic signed [W-1:0] xr_ext;
    logic signed [W-1:0] xi_ext;

    assign xr_ext = {{(W-B){signalr_i[B-1]}}, signalr_i};
    assign xi_ext = {{(W-B){signali_i[B-1]}}, signali_i};

    // Comb chain is purely combinational; only its delays and the outputs are registered.
    always_comb begin
        cr[0] = intr[N-1];
        ci[0] = inti[N-1];
        for (int k = 0; k < N; k++) begin
            cr[k+1] = cr[k] - zr[k];
            ci[k+1] = ci[k] - zi[k];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < N; k++) begin
                intr[k] <= '0;
                inti[k] <= '0;
                zr[k]   <= '0;
                zi[k]   <= '0;
            end
            count     <= '0;
            dec_q     <= 1'b0;
            signalr_o <= '0;
            signali_o <= '0;
            valid_o   <= 1'b0;
        end else begin
            if (valid_i) begin
                intr[0] <= intr[0] + xr_ext;
                inti[0] <= inti[0] + xi_ext;
                // Each stage adds the previous stage's registered value (one sample of delay).
                for (int k = 1; k < N; k++) begin
                    intr[k] <= intr[k] + intr[k-1];
                    inti[k] <= inti[k] + inti[k-1];
                end
                count <= count + 1'b1;
            end
            dec_q <= valid_i && (count == '1);
            if (dec_q) begin
                for (int k = 0; k < N; k++) begin
                    zr[k] <= cr[k];
                    zi[k] <= ci[k];
                end
                // Top B bits = arithmetic shift by N*L, exact unity DC gain.
                signalr_o <= cr[N][W-1 -: B];
                signali_o <= ci[N][W-1 -: B];
            end
            valid_o <= dec_q;
        end
    end

endmodule

// File: tb/tb_cic_decimator.sv
// Self-checking bench for cic_decimator: table-driven DC/wrap/gap/alternating vectors,
// a reset-in-flight sequence and a random-density run against a sample-domain model.
module tb_cic_decimator;

    localparam int B = 16;
    localparam int N = 3;
    localparam int L = 6;
    localparam int R = 1 << L;
    localparam int W = B + N * L;

    logic                clk_i = 1'b0;
    logic                rst_i = 1'b1;
    logic                valid_i = 1'b0;
    logic signed [B-1:0] signalr_i = '0;
    logic signed [B-1:0] signali_i = '0;
    logic signed [B-1:0] signalr_o;
    logic signed [B-1:0] signali_o;
    logic                valid_o;

    cic_decimator #(
        .num_of_bits_io (B),
        .num_of_stages  (N),
        .log2_decimation(L)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .signalr_i(signalr_i),
        .signali_i(signali_i),
        .signalr_o(signalr_o),
        .signali_o(signali_o),
        .valid_o  (valid_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;

    logic [2*B-1:0] exp_q[$];
    int             exp_cyc_q[$];

    int                  n_out    = 0;
    int                  prev_cyc = 0;
    int                  spacing  = 0;
    logic signed [B-1:0] last_r   = '0;
    logic signed [B-1:0] last_i   = '0;

    // Model: unbounded (64-bit) integrators/combs per accepted sample; the W-bit slice of
    // the exact result equals the modulo-2^W hardware result.
    logic signed [63:0] mir[N];
    logic signed [63:0] mii[N];
    logic signed [63:0] mzr[N];
    logic signed [63:0] mzi[N];
    int                 m_cnt = 0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < N; k++) begin
            mir[k] = 0;
            mii[k] = 0;
            mzr[k] = 0;
            mzi[k] = 0;
        end
        m_cnt = 0;
    endtask

    task automatic model_sample(input logic signed [B-1:0] r, input logic signed [B-1:0] i);
        logic signed [63:0] c_r, c_i, t;
        for (int k = N - 1; k >= 1; k--) begin
            mir[k] = mir[k] + mir[k-1];
            mii[k] = mii[k] + mii[k-1];
        end
        mir[0] = mir[0] + 64'(r);
        mii[0] = mii[0] + 64'(i);
        m_cnt++;
        if (m_cnt == R) begin
            m_cnt = 0;
            c_r = mir[N-1];
            c_i = mii[N-1];
            for (int k = 0; k < N; k++) begin
                t = c_r - mzr[k]; mzr[k] = c_r; c_r = t;
                t = c_i - mzi[k]; mzi[k] = c_i; c_i = t;
            end
            exp_q.push_back({c_r[W-1 -: B], c_i[W-1 -: B]});
            exp_cyc_q.push_back(cyc + 2);
        end
    endtask

    // ---------------- monitor (sampled on the falling edge) ----------------
    always @(negedge clk_i) begin
        logic [2*B-1:0] e;
        int             ec;
        if (valid_o === 1'b1) begin
            n_out++;
            spacing  = cyc - prev_cyc;
            prev_cyc = cyc;
            last_r   = signalr_o;
            last_i   = signali_o;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_valid_o: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                check("strobe_time", cyc, ec);
                check("out_r", signalr_o, $signed(e[2*B-1:B]));
                check("out_i", signali_o, $signed(e[B-1:0]));
            end
        end else if (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
            checks++;
            failures++;
            $display("FAIL missing_valid_o: got 0 expected 1 at cycle %0d", exp_cyc_q[0]);
            void'(exp_q.pop_front());
            void'(exp_cyc_q.pop_front());
        end
    end

    // ---------------- drivers ----------------
    task automatic drive(input bit v, input logic signed [B-1:0] r,
                         input logic signed [B-1:0] i);
        @(posedge clk_i);
        #1;
        valid_i   = v;
        signalr_i = r;
        signali_i = i;
        if (v) model_sample(r, i);
    endtask

    // One-cycle reset with valid_i held high to show it is ignored; checks cleared outputs.
    task automatic do_reset();
        @(posedge clk_i);
        #1;
        rst_i     = 1'b1;
        valid_i   = 1'b1;
        signalr_i = 16'sd1234;
        signali_i = -16'sd1234;
        @(posedge clk_i);
        #1;
        rst_i   = 1'b0;
        valid_i = 1'b0;
        exp_q.delete();
        exp_cyc_q.delete();
        model_clear();
        check("reset_valid_o", valid_o, 0);
        check("reset_signalr_o", signalr_o, 0);
        check("reset_signali_o", signali_o, 0);
        n_out    = 0;
        prev_cyc = cyc;
        spacing  = 0;
    endtask

    task automatic drain();
        repeat (4) drive(1'b0, '0, '0);
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string               name;
        logic signed [B-1:0] in_r;
        logic signed [B-1:0] in_i;
        bit                  alt;
        int                  gap;
        int                  n_samples;
        int                  exp_outs;
        logic signed [B-1:0] exp_r;
        logic signed [B-1:0] exp_i;
        int                  exp_spacing;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int samples;
        int k64;
        bit v;

        vecs[0] = '{"dc_1000",     16'sd1000,   -16'sd1000,  1'b0, 0, 320,   5,   16'sd1000,   -16'sd1000,  64};
        vecs[1] = '{"full_scale",  16'sd32767,  -16'sd32768, 1'b0, 0, 10000, 156, 16'sd32767,  -16'sd32768, 64};
        vecs[2] = '{"gapped_dc",   16'sd1000,   -16'sd1000,  1'b0, 1, 320,   5,   16'sd1000,   -16'sd1000,  128};
        vecs[3] = '{"alternating", 16'sd8000,   16'sd8000,   1'b1, 0, 320,   5,   16'sd0,      16'sd0,      64};
        vecs[4] = '{"dc_minus1",   -16'sd1,     16'sd1,      1'b0, 0, 256,   4,   -16'sd1,     16'sd1,      64};

        model_clear();
        repeat (2) @(posedge clk_i);

        for (int n = 0; n < 5; n++) begin
            do_reset();
            for (int s = 0; s < vecs[n].n_samples; s++) begin
                if (vecs[n].alt && (s % 2 == 1))
                    drive(1'b1, -vecs[n].in_r, -vecs[n].in_i);
                else
                    drive(1'b1, vecs[n].in_r, vecs[n].in_i);
                repeat (vecs[n].gap) drive(1'b0, '0, '0);
            end
            drain();
            check({vecs[n].name, "_outs"}, n_out, vecs[n].exp_outs);
            check({vecs[n].name, "_last_r"}, last_r, vecs[n].exp_r);
            check({vecs[n].name, "_last_i"}, last_i, vecs[n].exp_i);
            check({vecs[n].name, "_spacing"}, spacing, vecs[n].exp_spacing);
        end

        // Reset mid-operation: outputs clear, counter restarts, first strobe 2 clocks after
        // the 64th post-reset sample.
        do_reset();
        for (int s = 0; s < 4 * R + 30; s++) drive(1'b1, 16'sd1000, -16'sd1000);
        check("pre_reset_r", signalr_o, 16'sd1000);
        do_reset();
        k64 = 0;
        for (int s = 0; s < R; s++) begin
            drive(1'b1, 16'sd500, -16'sd500);
            k64 = cyc;
        end
        drain();
        check("post_reset_outs", n_out, 1);
        check("post_reset_strobe_cycle", prev_cyc, k64 + 2);

        // Random valid density and data against the model.
        do_reset();
        samples = 0;
        for (int c = 0; c < 3000; c++) begin
            v = 1'(($urandom_range(0, 1)));
            if (v) samples++;
            drive(v, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
        end
        drain();
        check("random_outs", n_out, samples / R);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
